dbus_uncached_axi: RTL and testbench
====================================

// Module: dbus_uncached_axi
// PURPOSE
//  Slave end of cpu_dbus_if: accepts CPU data-bus read/write requests and turns each
//  into one single-beat 32-bit AXI3 transaction on axi_req_t/axi_resp_t. Used for
//  uncached/MMIO accesses, beside D$ on the SoC AXI crossbar. One outstanding access.
// PARAMETERS
//  BUS_CACHE  4'b0000  value driven on arcache/awcache
//  BUS_PROT   3'b000   value driven on arprot/awprot
// PORTS
//  clk       in   1                  clock; all logic on posedge
//  rst       in   1                  synchronous, active-high reset
//  dbus      --   cpu_dbus_if.slave  read, write, address, wrdata, byteenable in; stall, rddata out
//  axi_req   out  axi_req_t          AXI master request channels
//  axi_resp  in   axi_resp_t         AXI master response channels
//  bus_error out  1                  only with DBUS_BUS_ERROR_EN (see CONFIGURATION)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). After reset: state IDLE;
//    arvalid/awvalid/wvalid/rready/bready=0; rddata=0; bus_error=0.
//  - Constant fields: arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01,
//    arlock=awlock=0, wlast=1, cache/prot from parameters.
//  - Request in IDLE: read|write sampled. Write takes priority if both are high
//    (illegal; read dropped). Latch address (aligned: [1:0] forced 0), wrdata, byteenable.
//  - FSM: IDLE -> RD_ADDR (arvalid=1 until arready) -> RD_DATA (rready=1 until rvalid;
//    capture rdata) -> DONE.
//    IDLE -> WR_REQ (awvalid and wvalid both 1; each drops independently on its ready;
//    both may complete same cycle) -> WR_RESP (bready=1 until bvalid) -> DONE.
//    DONE -> IDLE after exactly 1 cycle.
//  - stall is combinational: 1 when (IDLE & (read|write)), or in any state except IDLE/DONE.
//    It is 0 in DONE, and in IDLE with no request.
//    dbus.rddata holds captured rdata and is valid in the DONE cycle.
//    The CPU holds its request stable while stall=1; the request seen in DONE is the
//    finished one and is not reissued.
//  - Minimum latency: read 4 cycles request->stall low (IDLE, RD_ADDR, RD_DATA, DONE)
//    with zero-wait slave; write likewise 4.
//  - wstrb=latched byteenable. A write with byteenable=0 is still issued.
//    Reads always fetch the full word.
//  - Valids never drop before their ready (AXI rule). Address/data stable while valid.
//  - rst mid-transaction: FSM to IDLE, all valids/readies 0 next cycle. The interconnect
//    is reset by the same rst; no drain.
// CONFIGURATION
//  - DBUS_BUS_ERROR_EN defined: bus_error port exists. It pulses 1 in the DONE cycle when
//    the captured rresp/bresp != 2'b00 (OKAY). rddata is still returned.
//  - Not defined: no bus_error port; rresp/bresp ignored.
// STRUCTURE
//  - Shared package: dbus_axi_state_t enum (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE);
//    constants AXI_BURST_INCR=2'b01, AXI_SIZE_WORD=3'b010, AXI_RESP_OKAY=2'b00.
//  - Sub-module dbus_axi_wchan: tracks independent aw/w acceptance; outputs aw_done,
//    w_done, both_done.
// TESTING
//  1. Read 0x1FD0_F000, arready after 2 cycles, rvalid rdata=0xDEADBEEF after 3 more
//     -> one AR (arlen=0, arsize=2); stall low 1 cycle with rddata=0xDEADBEEF.
//  2. Write 0x1FD0_F004, wrdata=0x12345678, byteenable=4'b0011; wready before awready
//     -> wvalid drops first; wstrb=0011, wlast=1; single B handshake; stall low in DONE.
//  3. Back-to-back read then write, no idle cycle from CPU -> exactly one AR then one AW/W;
//     no duplicate transaction.
//  4. read=write=1 at 0x1000_0000 -> only AW/W issued; arvalid stays 0.
//  5. rst pulsed while in RD_DATA -> next cycle arvalid=rready=0, stall follows IDLE rule;
//     next read completes normally.
//  6. DBUS_BUS_ERROR_EN defined, bresp=2'b10 -> bus_error=1 for exactly the DONE cycle;
//     0 on a following OKAY read.

Source files
------------

// File: rtl/dbus_uncached_axi_pkg.sv
// Shared types and constants for the uncached data-bus to AXI3 bridge.
package dbus_uncached_axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      DONE
   } dbus_axi_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef struct packed {
      logic [31:0] araddr;
      logic [3:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic [1:0]  arlock;
      logic [3:0]  arcache;
      logic [2:0]  arprot;
      logic        arvalid;
      logic        rready;
      logic [31:0] awaddr;
      logic [3:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic [1:0]  awlock;
      logic [3:0]  awcache;
      logic [2:0]  awprot;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
   } axi_req_t;

   typedef struct packed {
      logic        arready;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rvalid;
      logic        awready;
      logic        wready;
      logic [1:0]  bresp;
      logic        bvalid;
   } axi_resp_t;

   // Word address in, byte address out with the sub-word bits cleared.
   function automatic logic [31:0] word_align(input logic [29:0] word_addr);
      return {word_addr, 2'b00};
   endfunction

endpackage

// File: rtl/dbus_uncached_axi_if.sv
// CPU data-bus interface: the CPU is the master, the bridge is the slave.
interface cpu_dbus_if;
   logic        read;
   logic        write;
   logic [31:0] address;
   logic [31:0] wrdata;
   logic [3:0]  byteenable;
   logic        stall;
   logic [31:0] rddata;

   modport master (output read, write, address, wrdata, byteenable,
                   input  stall, rddata);
   modport slave  (input  read, write, address, wrdata, byteenable,
                   output stall, rddata);
endinterface

// File: rtl/dbus_uncached_axi_wchan.sv
// Tracks AW and W acceptance independently so either may complete first.
module dbus_axi_wchan (
   input  logic clk,
   input  logic rst,
   input  logic awvalid,
   input  logic awready,
   input  logic wvalid,
   input  logic wready,
   output logic aw_done,
   output logic w_done,
   output logic both_done
);
   logic aw_seen;
   logic w_seen;

   assign aw_done   = aw_seen | (awvalid & awready);
   assign w_done    = w_seen  | (wvalid  & wready);
   assign both_done = aw_done & w_done;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || both_done) begin
         aw_seen <= 1'b0;
         w_seen  <= 1'b0;
      end else begin
         aw_seen <= aw_done;
         w_seen  <= w_done;
      end
   end
endmodule

// File: rtl/dbus_uncached_axi.sv
// Uncached CPU data-bus slave issuing single-beat 32-bit AXI3 transactions.
// Optional DBUS_BUS_ERROR_EN adds a bus_error pulse for non-OKAY responses.
module dbus_uncached_axi
   import dbus_uncached_axi_pkg::*;
#(
   parameter logic [3:0] BUS_CACHE = 4'b0000,
   parameter logic [2:0] BUS_PROT  = 3'b000
) (
   input  logic      clk,
   input  logic      rst,
   cpu_dbus_if.slave dbus,
   output axi_req_t  axi_req,
   input  axi_resp_t axi_resp
`ifdef DBUS_BUS_ERROR_EN
  ,output logic      bus_error
`endif
);
   dbus_axi_state_t state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [31:0] rddata_q;
   logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
   logic        aw_done, w_done, both_done;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^dbus.address[1:0];

   dbus_axi_wchan u_wchan (
      .clk       (clk),
      .rst       (rst),
      .awvalid   (awvalid_q),
      .awready   (axi_resp.awready),
      .wvalid    (wvalid_q),
      .wready    (axi_resp.wready),
      .aw_done   (aw_done),
      .w_done    (w_done),
      .both_done (both_done)
   );

   // NOTE: request payload registers carry no reset; they are only read while a valid is high.
   always_ff @(posedge clk) begin
      if (state == IDLE && (dbus.read || dbus.write)) begin
         addr_q  <= word_align(dbus.address[31:2]);
         wdata_q <= dbus.wrdata;
         be_q    <= dbus.byteenable;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         rddata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A simultaneous read is dropped in favour of the write.
               if (dbus.write) begin
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  state     <= WR_REQ;
               end else if (dbus.read) begin
                  arvalid_q <= 1'b1;
                  state     <= RD_ADDR;
               end
            end
            RD_ADDR: if (axi_resp.arready) begin
               arvalid_q <= 1'b0;
               rready_q  <= 1'b1;
               state     <= RD_DATA;
            end
            RD_DATA: if (axi_resp.rvalid) begin
               rready_q <= 1'b0;
               rddata_q <= axi_resp.rdata;
               state    <= DONE;
            end
            WR_REQ: begin
               if (aw_done) awvalid_q <= 1'b0;
               if (w_done)  wvalid_q  <= 1'b0;
               if (both_done) begin
                  bready_q <= 1'b1;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: if (axi_resp.bvalid) begin
               bready_q <= 1'b0;
               state    <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DBUS_BUS_ERROR_EN
   logic bus_error_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_error_q <= 1'b0;
      end else begin
         bus_error_q <= (state == RD_DATA && axi_resp.rvalid && axi_resp.rresp != AXI_RESP_OKAY) ||
                        (state == WR_RESP && axi_resp.bvalid && axi_resp.bresp != AXI_RESP_OKAY);
      end
   end

   assign bus_error = bus_error_q;
`else
   logic unused_resp;
   assign unused_resp = ^{axi_resp.rresp, axi_resp.bresp};
`endif

   assign dbus.stall  = (state == IDLE) ? (dbus.read | dbus.write) : (state != DONE);
   assign dbus.rddata = rddata_q;

   // NOTE: the struct gets a full default first so no field can infer a latch.
   always_comb begin
      axi_req         = '0;
      axi_req.araddr  = addr_q;
      axi_req.arsize  = AXI_SIZE_WORD;
      axi_req.arburst = AXI_BURST_INCR;
      axi_req.arcache = BUS_CACHE;
      axi_req.arprot  = BUS_PROT;
      axi_req.arvalid = arvalid_q;
      axi_req.rready  = rready_q;
      axi_req.awaddr  = addr_q;
      axi_req.awsize  = AXI_SIZE_WORD;
      axi_req.awburst = AXI_BURST_INCR;
      axi_req.awcache = BUS_CACHE;
      axi_req.awprot  = BUS_PROT;
      axi_req.awvalid = awvalid_q;
      axi_req.wdata   = wdata_q;
      axi_req.wstrb   = be_q;
      axi_req.wlast   = 1'b1;
      axi_req.wvalid  = wvalid_q;
      axi_req.bready  = bready_q;
   end
endmodule

// File: tb/tb_dbus_uncached_axi.sv
// Scoreboard bench for dbus_uncached_axi: stimulus queues expectations, a monitor checks them.
module tb_dbus_uncached_axi;
   import dbus_uncached_axi_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cpu_dbus_if dbus ();
   axi_req_t   axi_req;
   axi_resp_t  axi_resp;
`ifdef DBUS_BUS_ERROR_EN
   logic       bus_error;
`endif

   dbus_uncached_axi dut (
      .clk      (clk),
      .rst      (rst),
      .dbus     (dbus),
      .axi_req  (axi_req),
      .axi_resp (axi_resp)
`ifdef DBUS_BUS_ERROR_EN
     ,.bus_error(bus_error)
`endif
   );

   typedef struct { logic [31:0] data; logic [3:0] strb; logic aw_pending; } w_exp_t;
   typedef struct { logic is_write; logic [31:0] rdata; logic err; } done_exp_t;

   logic [31:0] exp_ar_q[$];
   logic [31:0] exp_aw_q[$];
   w_exp_t      exp_w_q[$];
   done_exp_t   exp_done_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- AXI slave model with per-channel wait counts ----------------
   int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
   logic [31:0] r_data = '0;
   logic [1:0]  r_resp = 2'b00;
   logic [1:0]  b_resp = 2'b00;

   initial begin
      int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
      bit  r_pend, aw_hs, w_hs;
      axi_resp = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            axi_resp = '0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            r_pend = 0; aw_hs = 0; w_hs = 0;
         end else begin
            if (axi_resp.arready) begin
               axi_resp.arready = 1'b0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
            end else if (axi_req.arvalid) begin
               if (ar_cnt >= ar_delay) axi_resp.arready = 1'b1; else ar_cnt++;
            end
            if (axi_resp.rvalid) begin
               axi_resp.rvalid = 1'b0;
            end else if (r_pend) begin
               if (r_cnt >= r_delay) begin
                  axi_resp.rvalid = 1'b1; axi_resp.rdata = r_data; axi_resp.rresp = r_resp; r_pend = 0;
               end else r_cnt++;
            end
            if (axi_resp.awready) begin
               axi_resp.awready = 1'b0; aw_cnt = 0; aw_hs = 1;
            end else if (axi_req.awvalid) begin
               if (aw_cnt >= aw_delay) axi_resp.awready = 1'b1; else aw_cnt++;
            end
            if (axi_resp.wready) begin
               axi_resp.wready = 1'b0; w_cnt = 0; w_hs = 1;
            end else if (axi_req.wvalid) begin
               if (w_cnt >= w_delay) axi_resp.wready = 1'b1; else w_cnt++;
            end
            if (axi_resp.bvalid) begin
               axi_resp.bvalid = 1'b0;
            end else if (aw_hs && w_hs) begin
               if (b_cnt >= b_delay) begin
                  axi_resp.bvalid = 1'b1; axi_resp.bresp = b_resp; aw_hs = 0; w_hs = 0; b_cnt = 0;
               end else b_cnt++;
            end
         end
      end
   end

   // ---------------- Monitor: protocol rules and scoreboard pops ----------------
   logic        p_ar_wait = 0, p_ar_hs = 0, p_aw_wait = 0, p_aw_hs = 0, p_w_wait = 0, p_w_hs = 0;
   logic [31:0] p_araddr, p_awaddr, p_wdata;

   initial begin
      logic [31:0] ea;
      w_exp_t      ew;
      done_exp_t   ed;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            p_ar_wait = 0; p_ar_hs = 0; p_aw_wait = 0; p_aw_hs = 0; p_w_wait = 0; p_w_hs = 0;
            continue;
         end
         if (p_ar_wait) begin
            check("ar_hold_valid", axi_req.arvalid, 1'b1);
            check("ar_hold_addr", axi_req.araddr, p_araddr);
         end
         if (p_aw_wait) begin
            check("aw_hold_valid", axi_req.awvalid, 1'b1);
            check("aw_hold_addr", axi_req.awaddr, p_awaddr);
         end
         if (p_w_wait) begin
            check("w_hold_valid", axi_req.wvalid, 1'b1);
            check("w_hold_data", axi_req.wdata, p_wdata);
         end
         if (p_ar_hs) check("ar_drop", axi_req.arvalid, 1'b0);
         if (p_aw_hs) check("aw_drop", axi_req.awvalid, 1'b0);
         if (p_w_hs)  check("w_drop", axi_req.wvalid, 1'b0);

         if (axi_req.arvalid && axi_resp.arready) begin
            check("ar_expected", exp_ar_q.size() != 0, 1'b1);
            if (exp_ar_q.size() != 0) begin
               ea = exp_ar_q.pop_front();
               check("ar_addr", axi_req.araddr, ea);
               check("ar_fields", {axi_req.arlen, axi_req.arsize, axi_req.arburst, axi_req.arlock,
                                   axi_req.arcache, axi_req.arprot},
                                  {4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
            end
         end
         if (axi_req.awvalid && axi_resp.awready) begin
            check("aw_expected", exp_aw_q.size() != 0, 1'b1);
            if (exp_aw_q.size() != 0) begin
               ea = exp_aw_q.pop_front();
               check("aw_addr", axi_req.awaddr, ea);
               check("aw_fields", {axi_req.awlen, axi_req.awsize, axi_req.awburst, axi_req.awlock,
                                   axi_req.awcache, axi_req.awprot},
                                  {4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
            end
         end
         if (axi_req.wvalid && axi_resp.wready) begin
            check("w_expected", exp_w_q.size() != 0, 1'b1);
            if (exp_w_q.size() != 0) begin
               ew = exp_w_q.pop_front();
               check("w_data", axi_req.wdata, ew.data);
               check("w_strb_last", {axi_req.wstrb, axi_req.wlast}, {ew.strb, 1'b1});
               check("w_before_aw", axi_req.awvalid & ~axi_resp.awready, ew.aw_pending);
            end
         end

         if (!dbus.stall && (dbus.read || dbus.write)) begin
            check("done_expected", exp_done_q.size() != 0, 1'b1);
            if (exp_done_q.size() != 0) begin
               ed = exp_done_q.pop_front();
               check("done_kind", dbus.write, ed.is_write);
               if (!ed.is_write) check("rddata", dbus.rddata, ed.rdata);
`ifdef DBUS_BUS_ERROR_EN
               check("bus_error_done", bus_error, ed.err);
`endif
            end
         end
`ifdef DBUS_BUS_ERROR_EN
         else begin
            check("bus_error_quiet", bus_error, 1'b0);
         end
`endif

         p_ar_wait = axi_req.arvalid & ~axi_resp.arready;
         p_aw_wait = axi_req.awvalid & ~axi_resp.awready;
         p_w_wait  = axi_req.wvalid  & ~axi_resp.wready;
         p_ar_hs   = axi_req.arvalid &  axi_resp.arready;
         p_aw_hs   = axi_req.awvalid &  axi_resp.awready;
         p_w_hs    = axi_req.wvalid  &  axi_resp.wready;
         p_araddr  = axi_req.araddr;
         p_awaddr  = axi_req.awaddr;
         p_wdata   = axi_req.wdata;
      end
   end

   // ---------------- Stimulus ----------------
   task automatic exp_read(input logic [31:0] addr, input logic [31:0] data, input logic err);
      exp_ar_q.push_back(addr);
      exp_done_q.push_back('{is_write: 1'b0, rdata: data, err: err});
   endtask

   task automatic exp_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                            input logic pend, input logic err);
      exp_aw_q.push_back(addr);
      exp_w_q.push_back('{data: data, strb: be, aw_pending: pend});
      exp_done_q.push_back('{is_write: 1'b1, rdata: 32'h0, err: err});
   endtask

   task automatic set_delays(input int ar, input int r, input int aw, input int w, input int b);
      ar_delay = ar; r_delay = r; aw_delay = aw; w_delay = w; b_delay = b;
   endtask

   task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be, output int cycles);
      @(negedge clk);
      dbus.read = rd; dbus.write = wr; dbus.address = addr; dbus.wrdata = wd; dbus.byteenable = be;
      #1 check("stall_idle_req", dbus.stall, 1'b1);
      cycles = 0;
      do begin
         @(negedge clk);
         #2;
         cycles++;
      end while (dbus.stall && cycles < 200);
      check("stall_release", dbus.stall, 1'b0);
   endtask

   task automatic cpu_idle();
      @(negedge clk);
      dbus.read = 1'b0; dbus.write = 1'b0;
   endtask

   initial begin
      int n;
      dbus.read = 1'b0; dbus.write = 1'b0; dbus.address = '0; dbus.wrdata = '0; dbus.byteenable = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #3;
      check("rst_valids", {axi_req.arvalid, axi_req.awvalid, axi_req.wvalid, axi_req.rready, axi_req.bready}, 5'b0);
      check("rst_rddata", dbus.rddata, 32'h0);
      check("rst_stall", dbus.stall, 1'b0);
`ifdef DBUS_BUS_ERROR_EN
      check("rst_bus_error", bus_error, 1'b0);
`endif

      // 1: read with wait states on AR and R
      set_delays(2, 3, 0, 0, 0); r_data = 32'hDEAD_BEEF; r_resp = 2'b00;
      exp_read(32'h1FD0_F000, 32'hDEAD_BEEF, 1'b0);
      cpu_access(1'b1, 1'b0, 32'h1FD0_F000, 32'h0, 4'h0, n);
      cpu_idle();

      // 2: write where W is accepted before AW
      set_delays(0, 0, 3, 1, 0); b_resp = 2'b00;
      exp_write(32'h1FD0_F004, 32'h1234_5678, 4'b0011, 1'b1, 1'b0);
      cpu_access(1'b0, 1'b1, 32'h1FD0_F004, 32'h1234_5678, 4'b0011, n);
      cpu_idle();

      // 3: back-to-back read then write, zero-wait slave, unaligned read address
      set_delays(0, 0, 0, 0, 0); r_data = 32'hCAFE_F00D;
      exp_read(32'h2000_0004, 32'hCAFE_F00D, 1'b0);
      cpu_access(1'b1, 1'b0, 32'h2000_0006, 32'h0, 4'h0, n);
      check("rd_latency", n, 3);
      exp_write(32'h2000_0010, 32'hA5A5_A5A5, 4'b1111, 1'b0, 1'b0);
      cpu_access(1'b0, 1'b1, 32'h2000_0010, 32'hA5A5_A5A5, 4'b1111, n);
      check("wr_latency", n, 3);
      cpu_idle();

      // 4: read and write together -> write only
      exp_write(32'h1000_0000, 32'h0BAD_F00D, 4'b1000, 1'b0, 1'b0);
      cpu_access(1'b1, 1'b1, 32'h1000_0000, 32'h0BAD_F00D, 4'b1000, n);
      cpu_idle();

      // zero byte-enable write is still issued; address is word-aligned
      exp_write(32'h3000_0008, 32'h5555_AAAA, 4'b0000, 1'b0, 1'b0);
      cpu_access(1'b0, 1'b1, 32'h3000_000A, 32'h5555_AAAA, 4'b0000, n);
      cpu_idle();

      // 5: reset while waiting in RD_DATA
      set_delays(0, 20, 0, 0, 0);
      exp_ar_q.push_back(32'h1FD0_F00C);
      @(negedge clk);
      dbus.read = 1'b1; dbus.address = 32'h1FD0_F00C;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         if (axi_req.rready) break;
      end
      check("t5_in_rd_data", axi_req.rready, 1'b1);
      @(negedge clk);
      rst = 1'b1; dbus.read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("t5_valids_cleared", {axi_req.arvalid, axi_req.rready}, 2'b00);
      check("t5_stall_idle", dbus.stall, 1'b0);
      set_delays(0, 0, 0, 0, 0); r_data = 32'h00C0_FFEE;
      exp_read(32'h1FD0_F008, 32'h00C0_FFEE, 1'b0);
      cpu_access(1'b1, 1'b0, 32'h1FD0_F008, 32'h0, 4'h0, n);
      cpu_idle();

      // 6: SLVERR on B, then an OKAY read
      b_resp = 2'b10;
      exp_write(32'h1FD0_F010, 32'hFEED_0001, 4'b1111, 1'b0, 1'b1);
      cpu_access(1'b0, 1'b1, 32'h1FD0_F010, 32'hFEED_0001, 4'b1111, n);
      b_resp = 2'b00; r_data = 32'h7777_0000;
      exp_read(32'h1FD0_F014, 32'h7777_0000, 1'b0);
      cpu_access(1'b1, 1'b0, 32'h1FD0_F014, 32'h0, 4'h0, n);
      cpu_idle();

      repeat (5) @(negedge clk);
      check("ar_queue_empty", exp_ar_q.size(), 0);
      check("aw_queue_empty", exp_aw_q.size(), 0);
      check("w_queue_empty", exp_w_q.size(), 0);
      check("done_queue_empty", exp_done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
